// File: rtl/grey_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : grey_to_bcd_seq_if
// Brief    : Input/output valid-ready bus for the sequential Gray-to-BCD decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface grey_to_bcd_seq_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] bcd_out;
    logic         bcd_err;
    logic [7:0]   conv_count;

    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bcd_out, bcd_err, conv_count
    );

    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bcd_out, bcd_err, conv_count
    );
endinterface
`default_nettype wire

// File: rtl/grey_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : grey_to_bcd_seq
// Brief    : Bit-serial Gray-to-binary decoder, MSB first, with BCD range flag
//            and a conversion counter.
// Revision : 1.0 - initial release
// ============================================================================
module grey_to_bcd_seq #(
    parameter int          W    = 4,
    parameter int unsigned MAXV = 9
) (
    input  wire                  clk,
    input  wire                  rst_n,
    grey_to_bcd_seq_if.slave     bus
);
    localparam int c_iw = (W > 2) ? $clog2(W - 1) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    logic [1:0]      r_state;
    logic [W-1:0]    r_g;
    logic [W-1:0]    r_b;
    logic [c_iw-1:0] r_idx;
    logic            r_err;
    logic [7:0]      r_count;

    logic [W-1:0]    w_b_next;
    logic            w_err;

    // Resolve the bit selected by r_idx; all other bits of the working value pass through.
    always_comb begin
        w_b_next = r_b;
        for (int i = 0; i < W - 1; i++) begin
            if (i == int'(r_idx)) begin
                w_b_next[i] = r_b[i+1] ^ r_g[i];
            end
        end
        w_err = (32'(w_b_next) > MAXV);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_g     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.in_valid) begin
                        r_g     <= bus.gray_in;
                        r_b     <= {bus.gray_in[W-1], {(W-1){1'b0}}};
                        r_idx   <= c_iw'(W - 2);
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    r_b <= w_b_next;
                    if (r_idx == '0) begin
                        r_err   <= w_err;
                        r_state <= c_done;
                    end else begin
                        r_idx <= r_idx - c_iw'(1);
                    end
                end
                c_done: begin
                    if (bus.out_ready) begin
                        r_count <= r_count + 8'd1;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == c_idle);
    assign bus.out_valid  = (r_state == c_done);
    assign bus.bcd_out    = r_b;
    assign bus.bcd_err    = r_err;
    assign bus.conv_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_grey_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_grey_to_bcd_seq
// Brief    : Scoreboard bench for grey_to_bcd_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grey_to_bcd_seq;
    localparam int W    = 4;
    localparam int MAXV = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    grey_to_bcd_seq_if #(.W(W)) bus ();

    grey_to_bcd_seq #(.W(W), .MAXV(MAXV)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mdl_cnt  = 0;
    int last_hs  = -1;
    bit b2b_chk  = 1'b0;
    bit prev_ov  = 1'b0;
    logic [W:0] exp_q[$];
    int         acc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inverse Gray found by search: the value whose Gray code equals g.
    function automatic logic [W:0] model(input logic [W-1:0] g);
        logic [W-1:0] v;
        for (int i = 0; i < (1 << W); i++) begin
            v = W'(i);
            if ((v ^ (v >> 1)) == g) return {(i > MAXV), v};
        end
        return '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.gray_in));
                acc_q.push_back(cyc + 1);
            end
            if (bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("latency_noacc", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(W - 1));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    chk("bcd_out", 32'(bus.bcd_out), 32'(e[W-1:0]));
                    chk("bcd_err", 32'(bus.bcd_err), 32'(e[W]));
                end
                chk("conv_count", 32'(bus.conv_count), 32'(mdl_cnt & 8'hff));
                mdl_cnt++;
                if (b2b_chk && last_hs >= 0) chk("period", 32'(cyc - last_hs), 32'(W + 1));
                last_hs = cyc;
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_q.delete();
        acc_q.delete();
        mdl_cnt = 0;
    endtask

    task automatic send(input logic [W-1:0] g);
        int n;
        bus.in_valid = 1'b1;
        bus.gray_in  = g;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 50);
        if (!bus.in_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.gray_in   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("rst_bcd_err", 32'(bus.bcd_err), 32'd0);
        chk("rst_conv_count", 32'(bus.conv_count), 32'd0);
        @(posedge clk);
        #1;

        send(4'b0000);
        send(4'b0111);
        send(4'b1111);
        send(4'b1000);
        drain();
        chk("count_after4", 32'(bus.conv_count), 32'd4);

        // Back-pressure: result held, extra word refused.
        bus.out_ready = 1'b0;
        send(4'b1111);
        bus.in_valid = 1'b1;
        bus.gray_in  = 4'b0011;
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_bcd_out", 32'(bus.bcd_out), 32'hA);
            chk("bp_bcd_err", 32'(bus.bcd_err), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(bus.conv_count), 32'd5);

        // Reset while idx==1 in SHIFT.
        do_reset();
        send(4'b1010);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_bcd_out", 32'(bus.bcd_out), 32'd0);
        chk("mid_rst_count", 32'(bus.conv_count), 32'd0);
        @(posedge clk);
        #1;
        send(4'b0111);
        drain();

        // Back-to-back over every code, then on to the 257-conversion wrap.
        do_reset();
        b2b_chk       = 1'b1;
        last_hs       = -1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            int n;
            bus.gray_in = W'(i % 16);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.in_ready && n < 50);
            if (!bus.in_ready) chk("b2b_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        b2b_chk = 1'b0;
        chk("wrap_count", 32'(bus.conv_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
